// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: address-region descriptor, target encoding
// and the default four-slave region table.
package soc_bus_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } region_t;

  typedef logic [3:0] tgt_t;

  localparam tgt_t UNMAPPED = 4'hF;

  localparam int DEF_NUM_REGIONS = 4;

  localparam region_t DEF_REGIONS [DEF_NUM_REGIONS] = '{
    '{base: 32'h0000_0000, mask: 32'hFFFF_0000},
    '{base: 32'h1000_0000, mask: 32'hFFFF_F000},
    '{base: 32'h2000_0000, mask: 32'hFFFF_F000},
    '{base: 32'h3000_0000, mask: 32'hFFFF_F000}
  };

endpackage

// File: rtl/bus_err_responder.sv
// Default slave for unmapped addresses: answers every accepted request one
// cycle later with an error response and zero read data.
module bus_err_responder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire,
  output logic              rvalid,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= fire;
    end
  end

  assign err   = rvalid;
  assign rdata = '0;

endmodule

// File: rtl/data_bus_demux.sv
// Single-master to NUM_SLAVES data bus demultiplexer with address decode,
// in-order outstanding tracking and an internal error responder.
module data_bus_demux
  import soc_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_SLAVES] = '{
    DEF_REGIONS[0].base, DEF_REGIONS[1].base, DEF_REGIONS[2].base, DEF_REGIONS[3].base},
  parameter logic [ADDR_W-1:0] REGION_MASK [NUM_SLAVES] = '{
    DEF_REGIONS[0].mask, DEF_REGIONS[1].mask, DEF_REGIONS[2].mask, DEF_REGIONS[3].mask}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               data_req,
  input  logic                               data_we,
  input  logic [DATA_W/8-1:0]                data_be,
  input  logic [ADDR_W-1:0]                  data_addr,
  input  logic [DATA_W-1:0]                  data_wdata,
  output logic                               data_gnt,
  output logic                               data_rvalid,
  output logic                               data_err,
  output logic [DATA_W-1:0]                  data_rdata,
  output logic [NUM_SLAVES-1:0]              s_req,
  output logic                               s_we,
  output logic [DATA_W/8-1:0]                s_be,
  output logic [ADDR_W-1:0]                  s_addr,
  output logic [DATA_W-1:0]                  s_wdata,
  input  logic [NUM_SLAVES-1:0]              s_gnt,
  input  logic [NUM_SLAVES-1:0]              s_rvalid,
  input  logic [NUM_SLAVES-1:0]              s_err,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_rdata,
  output logic                               proto_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  tgt_t              dec_tgt;
  tgt_t              tgt;
  logic [3:0]        cnt;
  logic              mapped;
  logic              issue_ok;
  logic              hs;
  logic              rsp;
  logic              unexp;
  logic              err_rvalid;
  logic              err_err;
  logic [DATA_W-1:0] err_rdata;

  // Scanning downwards lets the lowest matching index overwrite the others.
  function automatic tgt_t decode(input logic [ADDR_W-1:0] addr);
    tgt_t t;
    t = UNMAPPED;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i]) == REGION_BASE[i]) t = tgt_t'(i);
    end
    return t;
  endfunction

  assign s_we    = data_we;
  assign s_be    = data_be;
  assign s_addr  = data_addr;
  assign s_wdata = data_wdata;

  // Responses arrive in order, so a new target may only be addressed once
  // everything outstanding has drained.
  always_comb begin
    dec_tgt  = decode(data_addr);
    mapped   = (dec_tgt != UNMAPPED);
    issue_ok = rst && data_req && (cnt < MAX_CNT) && ((cnt == 4'd0) || (dec_tgt == tgt));
    s_req    = '0;
    data_gnt = issue_ok && !mapped;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (issue_ok && (dec_tgt == tgt_t'(i))) begin
        s_req[i] = 1'b1;
        data_gnt = s_gnt[i];
      end
    end
    hs = data_req && data_gnt;
  end

  always_comb begin
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    data_rdata  = '0;
    unexp       = 1'b0;
    if (tgt == UNMAPPED) begin
      data_rvalid = err_rvalid;
      data_err    = err_err;
      data_rdata  = err_rdata;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (tgt == tgt_t'(i)) begin
        data_rvalid = s_rvalid[i] && (cnt != 4'd0);
        data_err    = s_err[i];
        data_rdata  = s_rdata[i];
      end
      if (s_rvalid[i] && ((cnt == 4'd0) || (tgt != tgt_t'(i)))) unexp = 1'b1;
    end
    rsp = data_rvalid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      tgt       <= UNMAPPED;
      proto_err <= 1'b0;
    end else begin
      case ({hs, rsp})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
      if (hs) tgt <= dec_tgt;
      proto_err <= unexp;
    end
  end

  bus_err_responder #(
    .DATA_W (DATA_W)
  ) u_err_rsp (
    .clk    (clk),
    .rst    (rst),
    .fire   (hs && !mapped),
    .rvalid (err_rvalid),
    .err    (err_err),
    .rdata  (err_rdata)
  );

endmodule

// File: doc/data_bus_demux.md
DATA_BUS_DEMUX -- requirements
Module: data_bus_demux

Interface
REQ-001 Param NUM_SLAVES, default 4, number of slave ports, legal 1..8.
REQ-002 Param DATA_W, default 32, data width, multiple of 8; byte-enable width BE_W = DATA_W/8.
REQ-003 Param ADDR_W, default 32, address width.
REQ-004 Param MAX_OUTST, default 2, max outstanding granted-but-unanswered transactions, legal 1..15.
REQ-005 Param REGION_BASE[NUM_SLAVES], default {0x0000_0000, 0x1000_0000, 0x2000_0000, 0x3000_0000}, region base per slave.
REQ-006 Param REGION_MASK[NUM_SLAVES], default {0xFFFF_0000, 0xFFFF_F000, 0xFFFF_F000, 0xFFFF_F000}, compare mask per slave.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 data_req / data_we  in  1 / 1  master request, write flag.
REQ-010 data_be / data_addr / data_wdata  in  BE_W / ADDR_W / DATA_W  master request fields.
REQ-011 data_gnt / data_rvalid / data_err  out  1 / 1 / 1  master grant, response valid, response error.
REQ-012 data_rdata  out  DATA_W  master read data.
REQ-013 s_req / s_we  out  NUM_SLAVES / 1  per-slave request, broadcast write flag.
REQ-014 s_be / s_addr / s_wdata  out  BE_W / ADDR_W / DATA_W  broadcast request fields.
REQ-015 s_gnt / s_rvalid / s_err  in  NUM_SLAVES each  per-slave grant, response valid, error.
REQ-016 s_rdata  in  NUM_SLAVES x DATA_W  per-slave read data.
REQ-017 proto_err  out  1  one-cycle pulse on unexpected slave response.

Function
REQ-018 Decode: slave i selected when (data_addr & REGION_MASK[i]) == REGION_BASE[i]; lowest index wins on overlap; no match = unmapped.
REQ-019 Tracking state: outstanding counter cnt (0..MAX_OUTST) and last-target register tgt (slave index or UNMAPPED).
REQ-020 Issue allowed when data_req and cnt < MAX_OUTST and (cnt == 0 or decoded target == tgt); otherwise all s_req low, data_gnt low.
REQ-021 Mapped issue: s_req[sel] = 1 combinationally, data_gnt = s_gnt[sel]; handshake completes on req&gnt same cycle.
REQ-022 Unmapped issue: data_gnt = 1 same cycle, no s_req asserted; internal responder returns data_rvalid=1, data_err=1, data_rdata=0 exactly one cycle later.
REQ-023 Response path: data_rvalid/err/rdata = s_rvalid/s_err/s_rdata of tgt, combinational, zero added latency, in order.
REQ-024 cnt +1 on handshake, -1 on response, unchanged when both in same cycle; tgt loads decoded target on every handshake.
REQ-025 s_rvalid from a slave other than tgt, or any s_rvalid while cnt == 0: ignored, not forwarded, proto_err pulses one cycle.
REQ-026 Broadcast fields s_we/s_be/s_addr/s_wdata = master fields unconditionally.
REQ-027 Master must hold request fields stable until grant; block does not register them.

Reset
REQ-028 rst low: cnt=0, tgt=UNMAPPED, internal responder idle, proto_err=0 immediately; s_req=0 and data_gnt=0 while rst low.
REQ-029 Reset mid-transaction discards outstanding responses; slaves are reset in the same domain.
REQ-030 After rst release, first request is issuable in the first clock cycle.

Structure
REQ-031 Shared package soc_bus_pkg holds region_t (base, mask), UNMAPPED encoding and default region table, reused by the top level.
REQ-032 One sub-module, bus_err_responder: the unmapped-address responder (1-cycle rvalid/err generator).
REQ-033 Target 150-300 lines of RTL; no memories, no multicycle paths.

Verification
REQ-034 Read 0x0000_0010, slave0 grants same cycle, rvalid next cycle with 0xDEAD_BEEF -> data_rdata=0xDEAD_BEEF, err=0, cnt back to 0.
REQ-035 Write 0x4000_0000 (unmapped) -> data_gnt same cycle, next cycle data_rvalid=1, data_err=1, data_rdata=0, no s_req.
REQ-036 Back-to-back reads to slave1, slave1 withholds responses, MAX_OUTST=2 -> two grants, third request stalled (s_req=0) until first response.
REQ-037 Read slave0 outstanding, next request to slave2 -> stalled until slave0 response, then issued same cycle cnt reaches 0.
REQ-038 Slave3 asserts s_rvalid while cnt=0 -> data_rvalid stays 0, proto_err=1 for exactly one cycle.
REQ-039 rst asserted with cnt=2 -> cnt=0 and s_req=0 immediately; new read after release completes normally.
